// File: rtl/sort_sequencer.sv
// Batch controller for the insertion_sort datapath: loads a batch, sorts it, streams it out.
// Optional sorter watchdog is enabled by defining SEQ_TIMEOUT_EN.
module sort_sequencer #(
  parameter int unsigned DW      = 16,
  parameter int unsigned CW      = 8,
  parameter int unsigned GAP     = 2,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          enable,
  input  logic [DW-1:0] s_din,
  input  logic          s_valid,
  input  logic          s_last,
  output logic          s_ready,
  output logic [DW-1:0] m_dout,
  output logic          m_valid,
  output logic          m_last,
  input  logic          m_ready,
  output logic [DW-1:0] srt_din,
  output logic          srt_push,
  output logic          srt_pop,
  output logic          srt_clear,
  output logic          srt_sort,
  input  logic [DW-1:0] srt_dout,
  input  logic          srt_full,
  input  logic          srt_empty,
  input  logic          srt_idle,
  output logic          busy,
  output logic [CW-1:0] count,
  output logic          ovf,
  output logic          err
);

  localparam int unsigned GW = (GAP < 1) ? 1 : $clog2(GAP + 1);

  typedef enum logic [2:0] {
    StIdle, StClr, StLoad, StSort, StOut, StWpop, StDrain
  } state_e;

  state_e        r_state;
  logic [GW-1:0] r_guard;
  logic          r_sort_sent;
  logic [DW-1:0] r_m_dout;
  logic          r_m_valid;
  logic          r_m_last;
  logic [DW-1:0] r_din;
  logic          r_push;
  logic          r_pop;
  logic          r_clear;
  logic          r_sort;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic w_guard_ok;
  logic w_ready_ok;
  logic w_s_ready;
  logic w_s_acc;
  logic w_timeout;

  assign w_guard_ok = (r_guard == '0);
  assign w_ready_ok = w_guard_ok & srt_idle;
  assign w_s_acc    = s_valid & w_s_ready;

  always_comb begin
    w_s_ready = 1'b0;
    if (enable) begin
      case (r_state)
        StLoad:  w_s_ready = w_ready_ok & ~srt_full;
        StDrain: w_s_ready = 1'b1;
        default: w_s_ready = 1'b0;
      endcase
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_wdog;
  logic          r_err;
  logic          w_waiting;

  assign w_waiting = enable & ~srt_idle & (r_state inside {StClr, StLoad, StSort, StWpop});
  assign w_timeout = w_waiting & (r_wdog == TW'(TIMEOUT - 1));
  assign err       = r_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_timeout) r_err <= 1'b1;
      if (!w_waiting || w_timeout) r_wdog <= '0;
      else                         r_wdog <= r_wdog + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // Every command is a level inversion followed by a GAP-cycle guard before srt_idle is trusted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= StIdle;
      r_guard     <= '0;
      r_sort_sent <= 1'b0;
      r_m_dout    <= '0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_din       <= '0;
      r_push      <= 1'b0;
      r_pop       <= 1'b0;
      r_clear     <= 1'b0;
      r_sort      <= 1'b0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
    end else if (!enable || w_timeout) begin
      r_state   <= StIdle;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else begin
      if (r_guard != '0) r_guard <= r_guard - 1'b1;
      case (r_state)
        StIdle: begin
          if (s_valid) begin
            r_clear <= ~r_clear;
            r_ovf   <= 1'b0;
            r_count <= '0;
            r_guard <= GW'(GAP);
            r_state <= StClr;
          end
        end
        StClr: begin
          if (w_ready_ok && srt_empty) r_state <= StLoad;
        end
        StLoad: begin
          if (w_s_acc) begin
            r_din   <= s_din;
            r_push  <= ~r_push;
            r_guard <= GW'(GAP);
            if (!(&r_count)) r_count <= r_count + 1'b1;
            if (s_last) begin
              r_sort_sent <= 1'b0;
              r_state     <= StSort;
            end
          end else if (w_ready_ok && srt_full) begin
            r_ovf   <= 1'b1;
            r_state <= StDrain;
          end
        end
        StDrain: begin
          if (w_s_acc && s_last) begin
            r_sort_sent <= 1'b0;
            r_state     <= StSort;
          end
        end
        StSort: begin
          // First guarded slot issues the sort, the second one waits for it to finish.
          if (w_ready_ok) begin
            if (!r_sort_sent) begin
              r_sort      <= ~r_sort;
              r_sort_sent <= 1'b1;
              r_guard     <= GW'(GAP);
            end else begin
              r_state <= StOut;
            end
          end
        end
        StOut: begin
          if (r_m_valid) begin
            if (m_ready) begin
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
              r_pop     <= ~r_pop;
              r_guard   <= GW'(GAP);
              if (r_count != '0) r_count <= r_count - 1'b1;
              r_state   <= StWpop;
            end
          end else if (srt_empty) begin
            r_state <= StIdle;
          end else begin
            r_m_valid <= 1'b1;
            r_m_dout  <= srt_dout;
            r_m_last  <= (r_count == CW'(1));
          end
        end
        StWpop: begin
          if (w_ready_ok) r_state <= StOut;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign s_ready   = w_s_ready;
  assign m_dout    = r_m_dout;
  assign m_valid   = r_m_valid;
  assign m_last    = r_m_last;
  assign srt_din   = r_din;
  assign srt_push  = r_push;
  assign srt_pop   = r_pop;
  assign srt_clear = r_clear;
  assign srt_sort  = r_sort;
  assign busy      = (r_state != StIdle);
  assign count     = r_count;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_sort_sequencer.sv
// Directed bench for sort_sequencer with a behavioural toggle-driven sorter of capacity CAP.
module tb_sort_sequencer;

  localparam int CAP  = 8;
  localparam int BUSY = 3;

  logic        clk = 1'b0;
  logic        rstn, enable;
  logic [15:0] s_din, m_dout, srt_din, srt_dout;
  logic        s_valid, s_last, s_ready, m_valid, m_last, m_ready;
  logic        srt_push, srt_pop, srt_clear, srt_sort, srt_full, srt_empty, srt_idle;
  logic        busy, ovf, err;
  logic [7:0]  count;

  always #5 clk = ~clk;

  sort_sequencer #(.DW(16), .CW(8), .GAP(2), .TIMEOUT(15)) dut (
    .clk(clk), .rstn(rstn), .enable(enable),
    .s_din(s_din), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_dout(m_dout), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .srt_din(srt_din), .srt_push(srt_push), .srt_pop(srt_pop), .srt_clear(srt_clear),
    .srt_sort(srt_sort), .srt_dout(srt_dout), .srt_full(srt_full), .srt_empty(srt_empty),
    .srt_idle(srt_idle), .busy(busy), .count(count), .ovf(ovf), .err(err)
  );

  // Sorter model: push appends, sort orders ascending, pop drops the head.
  logic [15:0] m_mem [CAP];
  logic [15:0] nx_mem [CAP];
  int          m_n, nx_n, m_busy, nx_busy;
  logic        p_push, p_pop, p_clr, p_sort;
  logic        force_busy = 1'b0;
  logic [15:0] t;

  always_comb begin
    nx_mem  = m_mem;
    nx_n    = m_n;
    nx_busy = (m_busy > 0) ? m_busy - 1 : 0;
    t       = '0;
    if (srt_clear != p_clr) begin
      nx_n    = 0;
      nx_busy = BUSY;
    end
    if (srt_push != p_push) begin
      if (nx_n < CAP) begin
        nx_mem[nx_n] = srt_din;
        nx_n         = nx_n + 1;
      end
      nx_busy = BUSY;
    end
    if (srt_pop != p_pop) begin
      for (int i = 0; i < CAP - 1; i++) nx_mem[i] = nx_mem[i+1];
      if (nx_n > 0) nx_n = nx_n - 1;
      nx_busy = BUSY;
    end
    if (srt_sort != p_sort) begin
      for (int i = 0; i < CAP; i++) begin
        for (int j = 0; j < CAP - 1; j++) begin
          if ((j < nx_n - 1 - i) && (nx_mem[j] > nx_mem[j+1])) begin
            t           = nx_mem[j];
            nx_mem[j]   = nx_mem[j+1];
            nx_mem[j+1] = t;
          end
        end
      end
      nx_busy = BUSY;
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_n    <= 0;
      m_busy <= 0;
      p_push <= 1'b0;
      p_pop  <= 1'b0;
      p_clr  <= 1'b0;
      p_sort <= 1'b0;
    end else begin
      m_mem  <= nx_mem;
      m_n    <= nx_n;
      m_busy <= nx_busy;
      p_push <= srt_push;
      p_pop  <= srt_pop;
      p_clr  <= srt_clear;
      p_sort <= srt_sort;
    end
  end

  assign srt_idle  = (m_busy == 0) && !force_busy;
  assign srt_full  = (m_n == CAP);
  assign srt_empty = (m_n == 0);
  assign srt_dout  = m_mem[0];

  // Toggle counters and output-beat monitor.
  int   push_cnt = 0, pop_cnt = 0;
  logic q_push = 1'b0, q_pop = 1'b0;
  always @(posedge clk) begin
    q_push <= srt_push;
    q_pop  <= srt_pop;
    if (srt_push != q_push) push_cnt <= push_cnt + 1;
    if (srt_pop != q_pop)   pop_cnt  <= pop_cnt + 1;
  end

  logic [15:0] rx_d [$];
  logic        rx_l [$];
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      rx_d.push_back(m_dout);
      rx_l.push_back(m_last);
    end
  end

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_word(input logic [15:0] d, input logic l);
    int n;
    n       = 0;
    s_valid = 1'b1;
    s_din   = d;
    s_last  = l;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("batch_done", 32'(busy), 32'd0);
  endtask

  typedef struct {
    int   in_off;
    int   in_len;
    int   ex_off;
    int   ex_len;
    logic ovf;
  } vec_t;

  vec_t        tbl [7];
  logic [15:0] in_w [32];
  logic [15:0] ex_w [30];

  task automatic run_vec(input int v);
    int base, pb, qb;
    base = rx_d.size();
    pb   = push_cnt;
    qb   = pop_cnt;
    for (int i = 0; i < tbl[v].in_len; i++)
      send_word(in_w[tbl[v].in_off + i], (i == tbl[v].in_len - 1));
    wait_done();
    chk($sformatf("v%0d_len", v), 32'(rx_d.size() - base), 32'(tbl[v].ex_len));
    for (int i = 0; i < tbl[v].ex_len; i++) begin
      if (base + i < rx_d.size()) begin
        chk($sformatf("v%0d_dout[%0d]", v, i), 32'(rx_d[base+i]), 32'(ex_w[tbl[v].ex_off + i]));
        chk($sformatf("v%0d_last[%0d]", v, i), 32'(rx_l[base+i]),
            32'(i == tbl[v].ex_len - 1));
      end
    end
    chk($sformatf("v%0d_ovf", v), 32'(ovf), 32'(tbl[v].ovf));
    chk($sformatf("v%0d_count", v), 32'(count), 32'd0);
    chk($sformatf("v%0d_pushes", v), 32'(push_cnt - pb), 32'(tbl[v].ex_len));
    chk($sformatf("v%0d_pops", v), 32'(pop_cnt - qb), 32'(tbl[v].ex_len));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_last"}, 32'(m_last), 32'd0);
    chk({tag, "_m_dout"}, 32'(m_dout), 32'd0);
    chk({tag, "_srt_din"}, 32'(srt_din), 32'd0);
    chk({tag, "_toggles"}, 32'({srt_push, srt_pop, srt_clear, srt_sort}), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          base, pb, stable, n;
    logic [15:0] held;
    logic        prev;

    in_w = '{16'd5, 16'd3, 16'd9, 16'd1, 16'd7,
             16'h7FFF,
             16'd10, 16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1,
             16'd4, 16'd4, 16'd2,
             16'hFFFF, 16'h0000, 16'h8000,
             16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1,
             16'd2, 16'd1};
    ex_w = '{16'd1, 16'd3, 16'd5, 16'd7, 16'd9,
             16'h7FFF,
             16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10,
             16'd2, 16'd4, 16'd4,
             16'h0000, 16'h8000, 16'hFFFF,
             16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8,
             16'd1, 16'd2};
    tbl[0] = '{0, 5, 0, 5, 1'b0};
    tbl[1] = '{5, 1, 5, 1, 1'b0};
    tbl[2] = '{6, 10, 6, 8, 1'b1};
    tbl[3] = '{16, 3, 14, 3, 1'b0};
    tbl[4] = '{19, 3, 17, 3, 1'b0};
    tbl[5] = '{22, 8, 20, 8, 1'b0};
    tbl[6] = '{30, 2, 28, 2, 1'b0};

    rstn    = 1'b0;
    enable  = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_din   = '0;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rstn = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) run_vec(v);

    // Output backpressure: first word must hold with no pop until accepted.
    m_ready = 1'b0;
    base    = rx_d.size();
    send_word(16'd3, 1'b0);
    send_word(16'd1, 1'b0);
    send_word(16'd2, 1'b1);
    n = 0;
    while (!m_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", 32'(m_valid), 32'd1);
    held   = m_dout;
    pb     = pop_cnt;
    stable = 0;
    chk("bp_head", 32'(held), 32'd1);
    repeat (20) begin
      @(negedge clk);
      if (m_valid && (m_dout == held) && (pop_cnt == pb)) stable++;
    end
    chk("bp_stable", 32'(stable), 32'd20);
    @(posedge clk);
    #1 m_ready = 1'b1;
    wait_done();
    chk("bp_len", 32'(rx_d.size() - base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (base + i < rx_d.size()) chk($sformatf("bp_dout[%0d]", i), 32'(rx_d[base+i]), 32'(i + 1));
    end
    chk("bp_pops", 32'(pop_cnt - pb), 32'd3);

    // Asynchronous reset in the middle of LOAD.
    send_word(16'd9, 1'b0);
    send_word(16'd8, 1'b0);
    send_word(16'd7, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd3);
    rstn = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_vec(6);

    // Enable low mid-load: FSM idles, count holds, next batch starts clean.
    send_word(16'd6, 1'b0);
    send_word(16'd5, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    chk("en_busy", 32'(busy), 32'd0);
    chk("en_s_ready", 32'(s_ready), 32'd0);
    chk("en_count", 32'(count), 32'd2);
    enable = 1'b1;
    run_vec(0);

`ifdef SEQ_TIMEOUT_EN
    prev = srt_sort;
    send_word(16'd4, 1'b0);
    send_word(16'd2, 1'b1);
    n = 0;
    while ((srt_sort == prev) && n < 100) begin
      @(negedge clk);
      n++;
    end
    force_busy = 1'b1;
    repeat (5) @(negedge clk);
    chk("to_err_early", 32'(err), 32'd0);
    n = 0;
    while (!err && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("to_err", 32'(err), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_m_valid", 32'(m_valid), 32'd0);
    force_busy = 1'b0;
    rstn       = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("to_err_cleared", 32'(err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
